multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle MIPS control FSM for the multicycle datapath.
- Adds the following over the base decoder:
  - I-type logic/compare ops (andi, ori, slti).
  - bne and jal.
  - A memory-ready handshake that stalls memory states.
  - Sticky illegal-opcode trap.
- Outputs are Moore-decoded from the registered state, so each control value is valid in the same cycle as its state.

Parameters:
- ENABLE_EXT, 1: when 1, andi/ori/slti/bne/jal are decoded; when 0, they trap as illegal.
- HAS_MEM_READY, 1: when 1, IF/MEM_RD/MEM_WR wait on mem_ready; when 0, mem_ready is ignored and treated as 1.
- ALUOP_W, 3: width of alu_op; must be ≥3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26], stable from ID onward
- mem_ready  in  1  memory completes the access this cycle
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 imm ext, 11 imm ext<<2
- ext_zero  out  1  1 zero-extend imm (andi/ori), 0 sign-extend
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write if zero (beq)
- pc_write_cond_ne  out  1  PC write if !zero (bne)
- alu_op  out  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- illegal_op  out  1  trap state active
- state_o  out  4  current state, for debug

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - State goes to IF.
  - While reset is high, all outputs are forced to defaults.
- Defaults: every output 0, except alu_src_b=01.
- Opcodes:
  - R 000000, j 000010, jal 000011, beq 000100, bne 000101
  - addi 001000, slti 001010, andi 001100, ori 001101
  - lw 100011, sw 101011
- States (4-bit) and their outputs/transitions:
  - IF:
    - Outputs: mem_read=1; alu_src_b=01; alu_op=add.
    - pc_write and ir_write are asserted only when mem_ready=1.
    - Stays in IF while !mem_ready; otherwise goes to ID.
  - ID:
    - Outputs: alu_src_b=11; alu_op=add (branch target into ALUOut).
    - Next state: lw/sw→MEM_ADDR; R→EXEC_R; addi/slti/andi/ori→EXEC_I; beq/bne→BRANCH; j→JUMP; jal→JAL; anything else→TRAP.
  - MEM_ADDR:
    - Outputs: alu_src_a=1; alu_src_b=10; alu_op=add.
    - lw→MEM_RD; sw→MEM_WR.
  - MEM_RD:
    - Outputs: i_or_d=1; mem_read=1.
    - Stays while !mem_ready; otherwise goes to WB_MEM.
  - MEM_WR:
    - Outputs: i_or_d=1.
    - mem_write is asserted every cycle in the state; the memory captures the write on the mem_ready cycle.
    - Stays while !mem_ready; otherwise goes to IF.
  - WB_MEM: reg_write=1; mem_to_reg=01; reg_dst=00; →IF.
  - EXEC_R: alu_src_a=1; alu_src_b=00; alu_op=funct; →WB_R.
  - WB_R: reg_write=1; reg_dst=01; →IF.
  - EXEC_I:
    - Outputs: alu_src_a=1; alu_src_b=10.
    - alu_op: add for addi, slt for slti, and for andi, or for ori.
    - ext_zero=1 for andi/ori.
    - →WB_I.
  - WB_I:
    - reg_write=1; reg_dst=00; mem_to_reg=00.
    - ext_zero stays held for andi/ori.
    - →IF.
  - BRANCH:
    - Outputs: alu_src_a=1; alu_src_b=00; alu_op=sub; pc_src=01.
    - beq→pc_write_cond=1; bne→pc_write_cond_ne=1.
    - →IF.
  - JUMP: pc_write=1; pc_src=10; →IF.
  - JAL:
    - pc_write=1; pc_src=10; reg_write=1; reg_dst=10; mem_to_reg=10.
    - The PC value written to $31 is the PC+4 already loaded in IF.
    - →IF.
  - TRAP:
    - illegal_op=1; all write enables 0.
    - Sticky until reset.
- Latencies (with no stalls):
  - lw: 5 cycles.
  - R/I-type ALU, sw: 4 cycles.
  - beq/bne/j/jal: 3 cycles.
  - Each mem_ready=0 cycle in IF/MEM_RD/MEM_WR adds one cycle.
- Boundary conditions:
  - Unreachable state encodings → next state IF, outputs default.
  - Reset during any state (including a stall or TRAP) → IF on the next edge-free evaluation. No partial writes may be asserted while reset is high.
  - An op change in non-ID states does not alter the path, except the per-state sub-selects listed above (lw/sw in MEM_ADDR, I-type op in EXEC_I/WB_I, beq/bne in BRANCH), which use the current op.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode localparams.
  - State encodings.
  - ALU op encodings.
  - Mux select encodings (pc_src, alu_src_b, reg_dst, mem_to_reg).
- The block is one sequential next-state process plus one combinational output decoder.
- Sub-module ctrl_out_decode (state, op, mem_ready → control outputs) is natural and is shared with a future pipelined decoder.

Test Plan:
- lw (op=100011), mem_ready=1 → states IF,ID,MEM_ADDR,MEM_RD,WB_MEM. In WB_MEM: reg_write=1, mem_to_reg=01.
- sw, mem_ready low for 2 cycles in MEM_WR → MEM_WR lasts 3 cycles with i_or_d=1 and mem_write=1 throughout, then IF.
- IF with mem_ready=0 for 3 cycles → pc_write=0 and ir_write=0 for those 3 cycles, then both =1 for exactly one cycle.
- ori (001101) → EXEC_I: alu_op=100, ext_zero=1. WB_I: reg_write=1, reg_dst=00. Same op with ENABLE_EXT=0 → TRAP, illegal_op=1.
- bne (000101) → BRANCH: pc_write_cond_ne=1, pc_write_cond=0, alu_op=001. jal (000011) → JAL: reg_dst=10, mem_to_reg=10, pc_write=1.
- op=111111 → TRAP, held for 10 cycles with no writes. Asserting reset mid-TRAP, and separately mid-EXEC_R, → state_o=IF immediately and all outputs at defaults.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multicycle MIPS control FSM and its output
// decoder: opcodes, state encodings, ALU operation codes and the datapath
// mux select values. No ports; imported by multicycle_ctrl_fsm and
// ctrl_out_decode.
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // State encodings. 4'd14 and 4'd15 are unused and recover to S_IF.
   typedef enum logic [3:0] {
      S_IF       = 4'd0,
      S_ID       = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WR   = 4'd4,
      S_WB_MEM   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_I     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   // ALU operation codes (zero-extended to ALUOP_W at the port)
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   // pc_src
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // alu_src_b
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // reg_dst
   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   // mem_to_reg
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // True for the I-type logic/compare ops that use a zero-extended immediate.
   function automatic logic is_zext_op(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_out_decode.sv
// ---------------------------------------------------------------------------
// ctrl_out_decode
// Moore output decoder for the multicycle control FSM. Purely combinational:
// control values are a function of the registered state, plus the current op
// for the per-state sub-selects (EXEC_I/WB_I/BRANCH) and mem_ready for the
// IF-stage PC/IR write enables.
// Ports:
//   state      in  4        current FSM state
//   op         in  6        IR[31:26]
//   mem_ready  in  1        effective memory-ready (already forced for no-handshake builds)
//   pc_src .. illegal_op    out  control outputs (see multicycle_ctrl_fsm)
// ---------------------------------------------------------------------------
module ctrl_out_decode
   import ctrl_pkg::*;
#(
   parameter int ENABLE_EXT = 1,
   parameter int ALUOP_W    = 3
) (
   input  logic [3:0]         state,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_zero,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               reg_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               pc_write_cond_ne,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal_op
);

   logic       ext_en;
   logic [2:0] alu_sel;

   assign ext_en = (ENABLE_EXT != 0);
   assign alu_op = ALUOP_W'(alu_sel);

   always_comb begin
      pc_src           = PC_SRC_ALU;
      alu_src_a        = 1'b0;
      alu_src_b        = SRCB_FOUR;
      ext_zero         = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = REG_DST_RT;
      mem_to_reg       = M2R_ALUOUT;
      reg_write        = 1'b0;
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      alu_sel          = ALU_ADD;
      illegal_op       = 1'b0;

      case (state)
         S_IF: begin
            // PC+4 and IR only commit on the cycle the fetch completes.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_sel   = ALU_ADD;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
         end
         S_ID: begin
            // Speculative branch target into ALUOut.
            alu_src_b = SRCB_IMM_SH2;
            alu_sel   = ALU_ADD;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_sel   = ALU_ADD;
         end
         S_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
         end
         S_MEM_WR: begin
            // Held for the whole stall; memory captures on the ready cycle.
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
            reg_dst    = REG_DST_RT;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
            alu_sel   = ALU_FUNCT;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = REG_DST_RD;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ext_zero  = ext_en && is_zext_op(op);
            if (ext_en) begin
               case (op)
                  OP_SLTI: alu_sel = ALU_SLT;
                  OP_ANDI: alu_sel = ALU_AND;
                  OP_ORI:  alu_sel = ALU_OR;
                  default: alu_sel = ALU_ADD;
               endcase
            end
         end
         S_WB_I: begin
            // Keep the extender mode stable while the result is written back.
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RT;
            mem_to_reg = M2R_ALUOUT;
            ext_zero   = ext_en && is_zext_op(op);
         end
         S_BRANCH: begin
            alu_src_a        = 1'b1;
            alu_src_b        = SRCB_RT;
            alu_sel          = ALU_SUB;
            pc_src           = PC_SRC_ALUOUT;
            pc_write_cond    = (op == OP_BEQ);
            pc_write_cond_ne = ext_en && (op == OP_BNE);
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
         end
         S_JAL: begin
            // $31 receives the PC already advanced to PC+4 during IF.
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = M2R_PC;
         end
         S_TRAP: begin
            illegal_op = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multicycle MIPS control FSM with I-type logic/compare ops, bne/jal, a
// memory-ready stall handshake and a sticky illegal-opcode trap.
// Ports:
//   clk, reset (asynchronous, active-high)
//   op         in   IR[31:26]
//   mem_ready  in   memory access completes this cycle
//   pc_src, alu_src_a, alu_src_b, ext_zero, i_or_d, mem_read, mem_write,
//   ir_write, reg_dst, mem_to_reg, reg_write, pc_write, pc_write_cond,
//   pc_write_cond_ne, alu_op, illegal_op   out  datapath controls
//   state_o    out  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int ENABLE_EXT    = 1,
   parameter int HAS_MEM_READY = 1,
   parameter int ALUOP_W       = 3   // must be >= 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_zero,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               reg_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               pc_write_cond_ne,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal_op,
   output logic [3:0]         state_o
);

   state_t state_reg;
   state_t state_next;
   logic   ready_eff;
   logic   ext_en;

   logic [1:0]         d_pc_src;
   logic               d_alu_src_a;
   logic [1:0]         d_alu_src_b;
   logic               d_ext_zero;
   logic               d_i_or_d;
   logic               d_mem_read;
   logic               d_mem_write;
   logic               d_ir_write;
   logic [1:0]         d_reg_dst;
   logic [1:0]         d_mem_to_reg;
   logic               d_reg_write;
   logic               d_pc_write;
   logic               d_pc_write_cond;
   logic               d_pc_write_cond_ne;
   logic [ALUOP_W-1:0] d_alu_op;
   logic               d_illegal_op;

   assign ready_eff = (HAS_MEM_READY != 0) ? mem_ready : 1'b1;
   assign ext_en    = (ENABLE_EXT != 0);
   assign state_o   = state_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IF;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = S_IF;
      case (state_reg)
         S_IF:       state_next = ready_eff ? S_ID : S_IF;
         S_ID: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEM_ADDR;
               OP_R:         state_next = S_EXEC_R;
               OP_ADDI:      state_next = S_EXEC_I;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               OP_SLTI, OP_ANDI, OP_ORI:
                             state_next = ext_en ? S_EXEC_I : S_TRAP;
               OP_BNE:       state_next = ext_en ? S_BRANCH : S_TRAP;
               OP_JAL:       state_next = ext_en ? S_JAL : S_TRAP;
               default:      state_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR: state_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_next = ready_eff ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_next = ready_eff ? S_IF : S_MEM_WR;
         S_WB_MEM:   state_next = S_IF;
         S_EXEC_R:   state_next = S_WB_R;
         S_WB_R:     state_next = S_IF;
         S_EXEC_I:   state_next = S_WB_I;
         S_WB_I:     state_next = S_IF;
         S_BRANCH:   state_next = S_IF;
         S_JUMP:     state_next = S_IF;
         S_JAL:      state_next = S_IF;
         S_TRAP:     state_next = S_TRAP;  // sticky until reset
         default:    state_next = S_IF;
      endcase
   end

   ctrl_out_decode #(
      .ENABLE_EXT (ENABLE_EXT),
      .ALUOP_W    (ALUOP_W)
   ) u_out_decode (
      .state            (state_reg),
      .op               (op),
      .mem_ready        (ready_eff),
      .pc_src           (d_pc_src),
      .alu_src_a        (d_alu_src_a),
      .alu_src_b        (d_alu_src_b),
      .ext_zero         (d_ext_zero),
      .i_or_d           (d_i_or_d),
      .mem_read         (d_mem_read),
      .mem_write        (d_mem_write),
      .ir_write         (d_ir_write),
      .reg_dst          (d_reg_dst),
      .mem_to_reg       (d_mem_to_reg),
      .reg_write        (d_reg_write),
      .pc_write         (d_pc_write),
      .pc_write_cond    (d_pc_write_cond),
      .pc_write_cond_ne (d_pc_write_cond_ne),
      .alu_op           (d_alu_op),
      .illegal_op       (d_illegal_op)
   );

   // Reset masks the decoder so that the IF fetch request (and any write
   // enable) cannot leak out while reset is still held.
   always_comb begin
      pc_src           = PC_SRC_ALU;
      alu_src_a        = 1'b0;
      alu_src_b        = SRCB_FOUR;
      ext_zero         = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_dst          = REG_DST_RT;
      mem_to_reg       = M2R_ALUOUT;
      reg_write        = 1'b0;
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      alu_op           = '0;
      illegal_op       = 1'b0;
      if (!reset) begin
         pc_src           = d_pc_src;
         alu_src_a        = d_alu_src_a;
         alu_src_b        = d_alu_src_b;
         ext_zero         = d_ext_zero;
         i_or_d           = d_i_or_d;
         mem_read         = d_mem_read;
         mem_write        = d_mem_write;
         ir_write         = d_ir_write;
         reg_dst          = d_reg_dst;
         mem_to_reg       = d_mem_to_reg;
         reg_write        = d_reg_write;
         pc_write         = d_pc_write;
         pc_write_cond    = d_pc_write_cond;
         pc_write_cond_ne = d_pc_write_cond_ne;
         alu_op           = d_alu_op;
         illegal_op       = d_illegal_op;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Drives the control FSM with directed and randomized instruction streams
// (random opcodes, random mem_ready stalls, random resets) and compares every
// cycle's state and control outputs with a path-based reference model.
// A second instance built without the extended ops is checked for trapping.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
   logic       alu_src_a, ext_zero, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_write, pc_write, pc_write_cond, pc_write_cond_ne, illegal_op;
   logic [2:0] alu_op;
   logic [3:0] state_o;

   // second instance: ENABLE_EXT = 0
   logic       reset_n, ready_n;
   logic [5:0] op_n;
   logic [1:0] pc_src_n, alu_src_b_n, reg_dst_n, mem_to_reg_n;
   logic       alu_src_a_n, ext_zero_n, i_or_d_n, mem_read_n, mem_write_n, ir_write_n;
   logic       reg_write_n, pc_write_n, pc_write_cond_n, pc_write_cond_ne_n, illegal_op_n;
   logic [2:0] alu_op_n;
   logic [3:0] state_o_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.ENABLE_EXT(1), .HAS_MEM_READY(1), .ALUOP_W(3)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .ext_zero(ext_zero), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
      .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
   );

   multicycle_ctrl_fsm #(.ENABLE_EXT(0), .HAS_MEM_READY(1), .ALUOP_W(3)) dut_noext (
      .clk(clk), .reset(reset_n), .op(op_n), .mem_ready(ready_n),
      .pc_src(pc_src_n), .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n),
      .ext_zero(ext_zero_n), .i_or_d(i_or_d_n), .mem_read(mem_read_n),
      .mem_write(mem_write_n), .ir_write(ir_write_n), .reg_dst(reg_dst_n),
      .mem_to_reg(mem_to_reg_n), .reg_write(reg_write_n), .pc_write(pc_write_n),
      .pc_write_cond(pc_write_cond_n), .pc_write_cond_ne(pc_write_cond_ne_n),
      .alu_op(alu_op_n), .illegal_op(illegal_op_n), .state_o(state_o_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each instruction is an ordered list of states; IF/MEM_RD/MEM_WR repeat
   // while mem_ready is low, TRAP repeats forever.
   logic [3:0] phase_q[$];
   int         pidx;
   logic [5:0] cur_op;

   task automatic build_path(input logic [5:0] o);
      phase_q.delete();
      phase_q.push_back(S_IF);
      phase_q.push_back(S_ID);
      case (o)
         OP_LW:  begin phase_q.push_back(S_MEM_ADDR); phase_q.push_back(S_MEM_RD); phase_q.push_back(S_WB_MEM); end
         OP_SW:  begin phase_q.push_back(S_MEM_ADDR); phase_q.push_back(S_MEM_WR); end
         OP_R:   begin phase_q.push_back(S_EXEC_R); phase_q.push_back(S_WB_R); end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:
                 begin phase_q.push_back(S_EXEC_I); phase_q.push_back(S_WB_I); end
         OP_BEQ, OP_BNE: phase_q.push_back(S_BRANCH);
         OP_J:   phase_q.push_back(S_JUMP);
         OP_JAL: phase_q.push_back(S_JAL);
         default: phase_q.push_back(S_TRAP);
      endcase
   endtask

   // Packed order: pc_src, alu_src_a, alu_src_b, ext_zero, i_or_d, mem_read,
   // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_write,
   // pc_write_cond, pc_write_cond_ne, alu_op, illegal_op
   function automatic logic [21:0] exp_ctl(input logic [3:0] ph, input logic [5:0] o, input logic rdy);
      logic [1:0] pcs, srcb, rdst, m2r;
      logic srca, ez, iord, mr, mw, irw, rw, pw, pwc, pwcn, ill;
      logic [2:0] aop;
      pcs = 2'b00; srcb = 2'b01; rdst = 2'b00; m2r = 2'b00;
      srca = 0; ez = 0; iord = 0; mr = 0; mw = 0; irw = 0; rw = 0;
      pw = 0; pwc = 0; pwcn = 0; ill = 0; aop = 3'b000;
      case (ph)
         S_IF:       begin mr = 1; pw = rdy; irw = rdy; end
         S_ID:       srcb = 2'b11;
         S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
         S_MEM_RD:   begin iord = 1; mr = 1; end
         S_MEM_WR:   begin iord = 1; mw = 1; end
         S_WB_MEM:   begin rw = 1; m2r = 2'b01; end
         S_EXEC_R:   begin srca = 1; srcb = 2'b00; aop = 3'b010; end
         S_WB_R:     begin rw = 1; rdst = 2'b01; end
         S_EXEC_I: begin
            srca = 1; srcb = 2'b10;
            ez = (o == 6'b001100) || (o == 6'b001101);
            aop = (o == 6'b001010) ? 3'b101 : (o == 6'b001100) ? 3'b011 :
                  (o == 6'b001101) ? 3'b100 : 3'b000;
         end
         S_WB_I:     begin rw = 1; ez = (o == 6'b001100) || (o == 6'b001101); end
         S_BRANCH: begin
            srca = 1; srcb = 2'b00; aop = 3'b001; pcs = 2'b01;
            pwc = (o == 6'b000100); pwcn = (o == 6'b000101);
         end
         S_JUMP:     begin pw = 1; pcs = 2'b10; end
         S_JAL:      begin pw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
         S_TRAP:     ill = 1;
         default: ;
      endcase
      return {pcs, srca, srcb, ez, iord, mr, mw, irw, rdst, m2r, rw, pw, pwc, pwcn, aop, ill};
   endfunction

   function automatic logic [25:0] observed();
      return {state_o, pc_src, alu_src_a, alu_src_b, ext_zero, i_or_d, mem_read,
              mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_write,
              pc_write_cond, pc_write_cond_ne, alu_op, illegal_op};
   endfunction

   // One clock: drive at negedge, compare 1 time unit later, advance model
   // after the rising edge.
   task automatic step(input logic rdy, input logic rst);
      logic [3:0] ph;
      @(negedge clk);
      mem_ready = rdy;
      reset     = rst;
      #1;
      if (rst) begin
         chk("reset_ctl", 32'(observed()), 32'({4'(S_IF), exp_ctl(4'hF, 6'd0, 1'b0)}));
      end else begin
         ph = phase_q[pidx];
         chk("ctl", 32'(observed()), 32'({ph, exp_ctl(ph, cur_op, rdy)}));
      end
      @(posedge clk);
      if (rst) begin
         pidx = 0;
      end else begin
         ph = phase_q[pidx];
         if (ph != S_TRAP && !((ph == S_IF || ph == S_MEM_RD || ph == S_MEM_WR) && !rdy))
            pidx++;
      end
   endtask

   // Runs one instruction to completion. if_st/mem_st force that many
   // not-ready cycles in IF / memory states; rst_cyc injects a reset at that
   // cycle; a TRAP is held trap_hold cycles, then cleared by reset.
   task automatic run_instr(input logic [5:0] o, input int if_st, input int mem_st,
                            input int rst_cyc, input int trap_hold, input bit rand_rdy);
      int cyc = 0;
      int trap_n = 0;
      int ifs = if_st;
      int mems = mem_st;
      bit done = 0;
      logic [3:0] ph;
      logic rdy;
      cur_op = o;
      op     = o;
      build_path(o);
      pidx = 0;
      while (!done) begin
         ph = phase_q[pidx];
         if (cyc == rst_cyc) begin
            step($urandom_range(0, 1) == 1, 1'b1);
         end else if (ph == S_TRAP && trap_n >= trap_hold) begin
            step(1'b1, 1'b1);
            done = 1;
         end else begin
            if (ph == S_IF && ifs > 0) begin
               rdy = 0; ifs--;
            end else if ((ph == S_MEM_RD || ph == S_MEM_WR) && mems > 0) begin
               rdy = 0; mems--;
            end else begin
               rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            step(rdy, 1'b0);
            if (ph == S_TRAP) trap_n++;
            if (pidx == phase_q.size()) done = 1;
         end
         cyc++;
         if (!done && cyc > 400) begin
            chk("timeout", 32'(cyc), 32'd0);
            done = 1;
         end
      end
      $display("instr op=%b cycles=%0d checks=%0d fails=%0d", o, cyc, n_checks, n_fail);
   endtask

   task automatic noext_seq(input string tag, input logic [5:0] o, input logic [3:0] e0,
                            input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3);
      logic [3:0] exp_st[4];
      exp_st[0] = e0; exp_st[1] = e1; exp_st[2] = e2; exp_st[3] = e3;
      @(negedge clk);
      reset_n = 1'b1;
      op_n    = o;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         chk(tag, 32'(state_o_n), 32'(exp_st[i]));
         chk({tag, "_ill"}, 32'(illegal_op_n), 32'(exp_st[i] == S_TRAP));
         chk({tag, "_rw"}, 32'({reg_write_n, pc_write_cond_ne_n, ext_zero_n}), 32'(0 + ((exp_st[i] == S_WB_I) ? 4 : 0)));
      end
   endtask

   localparam int N_OPS = 14;
   logic [5:0] op_tab[N_OPS];

   initial begin
      op_tab = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI,
                 OP_ORI, OP_LW, OP_SW, 6'b111111, 6'b000001, 6'b100000};
      reset = 1'b1; mem_ready = 1'b0; op = OP_R;
      reset_n = 1'b1; ready_n = 1'b1; op_n = OP_R;
      cur_op = OP_R;
      build_path(OP_R);
      pidx = 0;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);

      // directed
      run_instr(OP_LW,  0, 0, -1, 0, 0);
      run_instr(OP_SW,  0, 2, -1, 0, 0);
      run_instr(OP_R,   3, 0, -1, 0, 0);
      run_instr(OP_ORI, 0, 0, -1, 0, 0);
      run_instr(OP_BNE, 0, 0, -1, 0, 0);
      run_instr(OP_BEQ, 1, 0, -1, 0, 0);
      run_instr(OP_JAL, 0, 0, -1, 0, 0);
      run_instr(OP_J,   0, 0, -1, 0, 0);
      run_instr(6'b111111, 0, 0, -1, 10, 0);
      run_instr(OP_R,   0, 0, 2, 0, 0);     // reset while in EXEC_R
      run_instr(OP_LW,  2, 3, -1, 0, 0);

      // randomized
      for (int n = 0; n < 300; n++) begin
         logic [5:0] o;
         int rc;
         o  = op_tab[$urandom_range(0, N_OPS - 1)];
         rc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
         run_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), rc,
                   $urandom_range(1, 4), 1);
      end

      // ENABLE_EXT = 0 instance
      noext_seq("noext_ori",  OP_ORI,  S_IF, S_ID, S_TRAP,   S_TRAP);
      noext_seq("noext_jal",  OP_JAL,  S_IF, S_ID, S_TRAP,   S_TRAP);
      noext_seq("noext_addi", OP_ADDI, S_IF, S_ID, S_EXEC_I, 4'(S_WB_I));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
